// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Request/response bundle between the core and the iterative RV32M unit.
//   Request  (core -> unit): start, funct3, op_a, op_b, rd_in
//   Response (unit -> core): busy, done, result, rd_out, wb_enable
// The core side uses the master modport and the unit uses the slave modport.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       rd_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd_out;
  logic             wb_enable;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out, wb_enable
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out, wb_enable
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit placed after the register file.
// It uses one shift-add or restoring-divide step per cycle, for 32 steps.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous reset, active low
//   bus    muldiv_unit_if.slave
//          start/funct3/op_a/op_b/rd_in in
//          busy/done/result/rd_out/wb_enable out
// The algorithm assumes WIDTH = 32 because the iteration counter is 5 bits wide.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [4:0]       cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  // The MUL low word is the same for signed and unsigned operands,
  // so MUL is treated as unsigned.
  logic             in_sign_a;
  logic             in_sign_b;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;
  logic             in_div_zero;
  logic             in_div_ovf;

  assign in_sign_a = bus.op_a[WIDTH-1] &&
                     (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                      bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
  assign in_sign_b = bus.op_b[WIDTH-1] &&
                     (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 ||
                      bus.funct3 == 3'b110);
  assign in_mag_a  = in_sign_a ? -bus.op_a : bus.op_a;
  assign in_mag_b  = in_sign_b ? -bus.op_b : bus.op_b;

  assign in_div_zero = bus.funct3[2] && (bus.op_b == '0);
  assign in_div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                       (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (bus.op_b == '1);

  // The multiplier sits in the low half of prod_q and is consumed from bit 0.
  // Partial sums collect in the high half, and the whole register shifts right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

  // The dividend sits in quo_q and shifts out of its MSB into the partial remainder.
  // The quotient bits shift in at the bottom.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fin_result;

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_q  : quo_q;
  assign rem_fix  = sign_a_q ? -rem_q : rem_q;

  always_comb begin
    fin_result = prod_fix[2*WIDTH-1:WIDTH];
    if (op_q[2])
      fin_result = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00)
      fin_result = prod_fix[WIDTH-1:0];
  end

  // Control FSM and datapath. Every output is registered.
  // On the fast path the signs are cleared, so FIN passes the preloaded values through unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      prod_q        <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.rd_out    <= '0;
      bus.wb_enable <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.wb_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.funct3;
            rd_q     <= bus.rd_in;
            cnt_q    <= '0;
            bus.busy <= 1'b1;
            if (in_div_zero || in_div_ovf) begin
              sign_a_q <= 1'b0;
              sign_b_q <= 1'b0;
              quo_q    <= in_div_zero ? {WIDTH{1'b1}} : {1'b1, {(WIDTH-1){1'b0}}};
              rem_q    <= in_div_zero ? bus.op_a : '0;
              state    <= FIN;
            end else begin
              sign_a_q <= in_sign_a;
              sign_b_q <= in_sign_b;
              a_q      <= in_mag_a;
              b_q      <= in_mag_b;
              prod_q   <= {{WIDTH{1'b0}}, in_mag_b};
              quo_q    <= in_mag_a;
              rem_q    <= '0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (op_q[2]) begin
            if (!div_diff[WIDTH]) begin
              rem_q <= div_diff[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= div_shift[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
          end
          if (cnt_q == 5'd31)
            state <= FIN;
          else
            cnt_q <= cnt_q + 5'd1;
        end
        FIN: begin
          bus.result    <= fin_result;
          bus.rd_out    <= rd_q;
          bus.done      <= 1'b1;
          bus.wb_enable <= (rd_q != 5'd0);
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed testbench for muldiv_unit. The expected values are worked out by hand
// from RV32M semantics. Latency n counts the negedges after the accept edge k,
// so done appears at n = 33 on normal ops and at n = 1 on the fast path.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds a request for exactly one rising edge (edge k).
  // Returns at the negedge that follows edge k.
  task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] exp_res,
                              input logic [4:0] exp_rd, input int exp_lat);
    int n = 0;
    check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " rd_out"}, 32'(bus.rd_out), 32'(exp_rd));
    check({tag, " wb_enable"}, 32'(bus.wb_enable), 32'(exp_rd != 5'd0));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    apply_stimulus(f3, a, b, rd);
    check_output(tag, exp_res, rd, exp_lat);
  endtask

  initial begin
    int dones;
    int done_at;
    logic [31:0] seen_res;
    logic [4:0]  seen_rd;
    logic        seen_wb;

    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);
    check("reset wb_enable", 32'(bus.wb_enable), 32'd0);
    reset = 1'b1;

    $display("[TB] multiply");
    run_op("MUL 7x6",        3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       33);
    run_op("MUL -3x5",       3'b000, 32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFF1, 33);
    run_op("MULH -1x-1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, 33);
    run_op("MULHU max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
    run_op("MULHSU -1*max",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33);

    $display("[TB] divide");
    run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33);
    run_op("REM -7%2",       3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    run_op("DIV 7/-2",       3'b100, 32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, 33);
    run_op("REM 7%-2",       3'b110, 32'd7,        32'hFFFFFFFE, 5'd9,  32'd1,        33);
    run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       33);
    run_op("REMU 100%7",     3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        33);
    run_op("DIVU max/1",     3'b101, 32'hFFFFFFFF, 32'd1,        5'd11, 32'hFFFFFFFF, 33);

    $display("[TB] start while busy, rd=0");
    apply_stimulus(3'b000, 32'd3, 32'd3, 5'd0);
    dones    = 0;
    done_at  = -1;
    seen_res = '0;
    seen_rd  = '1;
    seen_wb  = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 3 || n == 10) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        bus.rd_in  = 5'd7;
      end else begin
        bus.start  = 1'b0;
      end
      if (bus.done) begin
        dones++;
        if (done_at < 0) begin
          done_at  = n;
          seen_res = bus.result;
          seen_rd  = bus.rd_out;
          seen_wb  = bus.wb_enable;
        end
      end
    end
    check("busy-start done count", 32'(dones), 32'd1);
    check("busy-start latency", 32'(done_at), 32'd33);
    check("busy-start result", seen_res, 32'd9);
    check("busy-start rd_out", 32'(seen_rd), 32'd0);
    check("busy-start wb_enable", 32'(seen_wb), 32'd0);

    $display("[TB] fast path");
    run_op("DIVU 5/0",       3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1);
    run_op("REM 5%0",        3'b110, 32'd5,        32'd0,        5'd13, 32'd5,        1);
    run_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
    run_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1);
    run_op("REM -5%0",       3'b110, 32'hFFFFFFFB, 32'd0,        5'd3,  32'hFFFFFFFB, 1);

    $display("[TB] reset mid-operation");
    apply_stimulus(3'b100, 32'd1000, 32'hFFFFFFFD, 5'd9);
    repeat (15) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset result", bus.result, 32'd0);
    check("midreset rd_out", 32'(bus.rd_out), 32'd0);
    check("midreset wb_enable", 32'(bus.wb_enable), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midreset no done", 32'(dones), 32'd0);
    run_op("DIVU 9/3 after reset", 3'b101, 32'd9, 32'd3, 5'd4, 32'd3, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
